// File: rtl/fm_max_pool_float16.sv
// rtl/fm_max_pool_float16.sv - per-lane float16 max pooling over POOL_SIZE^2 beats with optional ReLU
module fm_max_pool_float16 #(
    parameter int DATA_WIDTH = 16,
    parameter int PARA_Y     = 3,
    parameter int POOL_SIZE  = 2,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_relu_en,
    input  logic                         i_din_valid,
    input  logic [PARA_Y*DATA_WIDTH-1:0] i_din,
    output logic                         o_din_ready,
    output logic                         o_dout_valid,
    input  logic                         i_dout_ready,
    output logic [PARA_Y*DATA_WIDTH-1:0] o_dout,
    output logic                         o_busy
);

    localparam int W = POOL_SIZE * POOL_SIZE;
    localparam int MAN_W = 10;
    localparam logic [DATA_WIDTH-1:0] NEG_INF   = DATA_WIDTH'(16'hFC00);
    localparam logic [DATA_WIDTH-1:0] QNAN      = DATA_WIDTH'(16'h7E00);
    localparam logic [DATA_WIDTH-1:0] SIGN_MASK = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [CNT_WIDTH-1:0]          r_cnt;
    logic [DATA_WIDTH-1:0]         r_acc [PARA_Y];
    logic [PARA_Y*DATA_WIDTH-1:0]  r_dout;
    logic [DATA_WIDTH-1:0]         w_max [PARA_Y];
    logic [PARA_Y*DATA_WIDTH-1:0]  w_result;
    logic                          w_accept;
    logic                          w_last;
    logic                          w_clear;

    function automatic logic f_is_nan(input logic [DATA_WIDTH-1:0] x);
        return (&x[DATA_WIDTH-2:MAN_W]) && (|x[MAN_W-1:0]);
    endfunction

    // Sign-magnitude mapped onto an unsigned total order (-0 sorts below +0)
    function automatic logic [DATA_WIDTH-1:0] f_key(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? ~x : (x | SIGN_MASK);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_max(input logic [DATA_WIDTH-1:0] acc,
                                                    input logic [DATA_WIDTH-1:0] x);
        if (f_is_nan(acc) || f_is_nan(x)) return QNAN;
        return (f_key(x) > f_key(acc)) ? x : acc;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_relu(input logic [DATA_WIDTH-1:0] x,
                                                     input logic en);
        if (en && x[DATA_WIDTH-1] && !f_is_nan(x)) return '0;
        return x;
    endfunction

    genvar j;
    generate
        for (j = 0; j < PARA_Y; j++) begin : g_lane
            assign w_max[j] = f_max(r_acc[j], i_din[DATA_WIDTH*j +: DATA_WIDTH]);
            assign w_result[DATA_WIDTH*j +: DATA_WIDTH] = f_relu(w_max[j], i_relu_en);
        end
    endgenerate

    // start has priority over a same-cycle beat in ACCUM, so that beat is dropped
    assign w_accept = (r_state == S_ACCUM) && i_din_valid && !i_start;
    assign w_last   = w_accept && (r_cnt == CNT_WIDTH'(W-1));
    assign w_clear  = i_start && ((r_state != S_OUT) || i_dout_ready);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_ACCUM;
            S_ACCUM: if (!i_start && w_last) w_next = S_OUT;
            S_OUT:   if (i_dout_ready) w_next = i_start ? S_ACCUM : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_din_ready  = (r_state == S_ACCUM);
        o_dout_valid = (r_state == S_OUT);
        o_busy       = (r_state != S_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt  <= '0;
            r_dout <= '0;
            for (int k = 0; k < PARA_Y; k++) r_acc[k] <= NEG_INF;
        end else if (w_clear) begin
            r_cnt <= '0;
            for (int k = 0; k < PARA_Y; k++) r_acc[k] <= NEG_INF;
        end else if (w_accept) begin
            if (!w_last) r_cnt <= r_cnt + 1'b1;
            for (int k = 0; k < PARA_Y; k++) r_acc[k] <= w_max[k];
            if (w_last) r_dout <= w_result;
        end
    end

    assign o_dout = r_dout;

endmodule

// File: tb/tb_fm_max_pool_float16.sv
// tb/tb_fm_max_pool_float16.sv - directed self-checking bench for fm_max_pool_float16
module tb_fm_max_pool_float16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        relu_en = 1'b0;
    logic        din_valid = 1'b0;
    logic [47:0] din = '0;
    logic        din_ready;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [47:0] dout;
    logic        busy;

    int checks = 0;
    int failures = 0;

    fm_max_pool_float16 dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_relu_en    (relu_en),
        .i_din_valid  (din_valid),
        .i_din        (din),
        .o_din_ready  (din_ready),
        .o_dout_valid (dout_valid),
        .i_dout_ready (dout_ready),
        .o_dout       (dout),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] l2);
        din = {l2, l1, l0};
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic release_out();
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_din_ready", 64'(din_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        rst = 1'b1;
        tick();
        check("idle_din_ready", 64'(din_ready), 64'd0);

        // window 1: mixed, all-negative and signed-zero lanes with a stall
        pulse_start();
        check("w1_din_ready", 64'(din_ready), 64'd1);
        check("w1_busy", 64'(busy), 64'd1);
        beat(16'h3C00, 16'hBC00, 16'h8000);
        beat(16'h4000, 16'hC000, 16'h0000);
        for (int i = 0; i < 3; i++) tick();
        check("w1_stall_state", 64'(din_ready), 64'd1);
        beat(16'hC000, 16'hC200, 16'h8000);
        check("w1_not_yet_valid", 64'(dout_valid), 64'd0);
        beat(16'h3800, 16'hBC00, 16'h8000);
        check("w1_valid_latency", 64'(dout_valid), 64'd1);
        check("w1_dout", 64'(dout), 64'h0000_BC00_4000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("w1_hold_valid", 64'(dout_valid), 64'd1);
            check("w1_hold_din_ready", 64'(din_ready), 64'd0);
            check("w1_hold_dout", 64'(dout), 64'h0000_BC00_4000);
        end
        // start without dout_ready is ignored
        pulse_start();
        check("w1_start_ignored", 64'(dout_valid), 64'd1);
        release_out();
        check("w1_released_valid", 64'(dout_valid), 64'd0);
        check("w1_released_busy", 64'(busy), 64'd0);

        // window 2: same data with ReLU, then back-to-back handoff
        relu_en = 1'b1;
        pulse_start();
        beat(16'h3C00, 16'hBC00, 16'h8000);
        beat(16'h4000, 16'hC000, 16'h0000);
        beat(16'hC000, 16'hC200, 16'h8000);
        beat(16'h3800, 16'hBC00, 16'h8000);
        check("w2_valid", 64'(dout_valid), 64'd1);
        check("w2_dout_relu", 64'(dout), 64'h0000_0000_4000);
        relu_en = 1'b0;
        start = 1'b1;
        dout_ready = 1'b1;
        tick();
        start = 1'b0;
        dout_ready = 1'b0;
        check("b2b_accum", 64'(din_ready), 64'd1);
        check("b2b_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) beat(16'h4200, 16'h4200, 16'h4200);
        check("b2b_valid", 64'(dout_valid), 64'd1);
        check("b2b_dout", 64'(dout), 64'h4200_4200_4200);
        release_out();

        // window 4: NaN sticky with ReLU, negative lane clamps, +inf wins
        relu_en = 1'b1;
        pulse_start();
        beat(16'h3C00, 16'hC400, 16'h7C00);
        beat(16'h7E01, 16'hC400, 16'h3C00);
        beat(16'hC000, 16'hC400, 16'hFC00);
        beat(16'h3800, 16'hC400, 16'h0000);
        check("nan_valid", 64'(dout_valid), 64'd1);
        check("nan_dout", 64'(dout), 64'h7C00_0000_7E00);
        relu_en = 1'b0;
        release_out();

        // asynchronous reset mid-window discards partial data
        pulse_start();
        beat(16'h5000, 16'h5000, 16'h5000);
        beat(16'h5000, 16'h5000, 16'h5000);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_dout", 64'(dout), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        pulse_start();
        for (int i = 0; i < 4; i++) beat(16'h3800, 16'h3800, 16'h3800);
        check("post_rst_dout", 64'(dout), 64'h3800_3800_3800);
        release_out();

        // start during ACCUM after 3 beats restarts; same-cycle beat dropped
        pulse_start();
        for (int i = 0; i < 3; i++) beat(16'h5000, 16'h5000, 16'h5000);
        start = 1'b1;
        din_valid = 1'b1;
        din = {16'h5000, 16'h5000, 16'h5000};
        tick();
        start = 1'b0;
        din_valid = 1'b0;
        for (int i = 0; i < 3; i++) beat(16'h3400, 16'h3400, 16'h3400);
        check("restart_not_valid", 64'(dout_valid), 64'd0);
        beat(16'h3400, 16'h3400, 16'h3400);
        check("restart_valid", 64'(dout_valid), 64'd1);
        check("restart_dout", 64'(dout), 64'h3400_3400_3400);
        release_out();
        check("final_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fm_max_pool_float16.md
Name: fm_max_pool_float16

Overview:
- Downstream consumer of the feature-map RAM's pool read port (read_type 1).
- Each read returns PARA_Y float16 lanes, one lane per output column.
- The block accepts POOL_SIZE*POOL_SIZE such beats, keeps a per-lane running maximum, and presents PARA_Y pooled results with an optional ReLU clamp.
- A valid/ready handshake hands the results to the next write stage (ena_w path of the feature-map RAM).

Parameters:
- DATA_WIDTH, 16, element width (IEEE-754 binary16).
- PARA_Y, 3, number of parallel lanes per beat.
- POOL_SIZE, 2, window edge; beats per window W = POOL_SIZE*POOL_SIZE.
- CNT_WIDTH, 4, beat counter width; must satisfy 2^CNT_WIDTH >= W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that opens a new window.
- relu_en  in  1  1 = clamp negative results to +0 at output.
- din_valid  in  1  beat on din is valid.
- din  in  PARA_Y*DATA_WIDTH  lane j in bits [DATA_WIDTH*(j+1)-1 : DATA_WIDTH*j].
- din_ready  out  1  block accepts a beat this cycle.
- dout_valid  out  1  pooled result valid.
- dout_ready  in  1  consumer takes dout this cycle.
- dout  out  PARA_Y*DATA_WIDTH  pooled lanes, same packing as din.
- busy  out  1  high in ACCUM or OUT.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, all accumulators=0xFC00 (-inf), dout=0, dout_valid=0, din_ready=0, busy=0. Reset mid-window discards all partial data.

FSM IDLE:
- din_ready=0.
- start=1 -> ACCUM; cnt<=0; acc[j]<=0xFC00.

FSM ACCUM:
- din_ready=1; busy=1.
- A beat is accepted when din_valid=1: acc[j]<=max(acc[j], din[j]); cnt<=cnt+1.
- Accepting the beat with cnt==W-1 -> OUT. dout[j]<=final max, with ReLU applied if relu_en; dout_valid<=1 on the next edge.
- Latency is one cycle from the last accepted beat to dout_valid.
- start=1 in ACCUM restarts the window: cnt<=0, acc<=-inf. A din beat in the same cycle is dropped.
- din_valid=0 cycles are stalls; state is held.

FSM OUT:
- din_ready=0; dout_valid=1; dout is held stable until the handshake completes.
- dout_ready=1 -> dout_valid<=0 and IDLE.
- If start=1 in the same cycle, go directly to ACCUM with cleared accumulators. This gives back-to-back windows with no idle cycle.
- start=1 without dout_ready is ignored.

Compare rule (pure logic, no FP IP):
- Key k(x) = x[15] ? ~x : (x | 0x8000); compare keys unsigned.
- Total order, so +0 (0x0000) > -0 (0x8000). On equal keys the accumulator is kept.
- NaN (exp=5'h1F, mant!=0) on either operand: result = canonical 0x7E00, and it is sticky for the rest of the window.
- +inf and -inf compare normally.

ReLU:
- Applied only at output latch.
- relu_en=1 and result sign=1 and not NaN -> 0x0000.
- NaN passes unchanged.
- relu_en is sampled on the cycle of the last accepted beat.

Counter:
- cnt counts 0..W-1 and never wraps in ACCUM; the transition to OUT occurs exactly at W-1.

Test Plan:
- W=4, relu_en=0; start, then beats lane0 {0x3C00, 0x4000, 0xC000, 0x3800} -> dout lane0=0x4000, dout_valid high exactly 1 cycle after the 4th beat.
- All lanes negative, lane1 {0xBC00, 0xC000, 0xC200, 0xBC00}: relu_en=0 -> 0xBC00; the same data with relu_en=1 -> 0x0000.
- Lane2 {0x8000, 0x0000, 0x8000, 0x8000} -> 0x0000. Lane0 containing 0x7E01 in beat 2 -> 0x7E00, including with relu_en=1.
- Hold din_valid=0 for 3 cycles between beats 2 and 3, and hold dout_ready=0 for 5 cycles in OUT -> result unchanged, din_ready=0 throughout OUT.
- start pulsed with dout_ready=1 in OUT, followed by 4 beats of 0x4200 -> second dout=0x4200 in every lane, with no IDLE cycle between windows.
- rst pulled low after 2 beats, then a fresh window {0x3800 x4} -> dout=0x3800, proving earlier partial data was discarded. Also covered: start during ACCUM after 3 beats restarts the count, and dout_valid appears only after 4 further beats.
